vga_frame_counter: RTL

//  Free-running VGA timing counter; the stage directly upstream of the VSync/HSync generators.

---
 rtl/vga_frame_counter.sv | 89 ++++++++
 1 files changed

// File: rtl/vga_frame_counter.sv
// vga_frame_counter
// Free-running VGA raster timing counter. It keeps three registered counters:
//   - the tick within the line
//   - the line within the frame
//   - the tick within the frame
// All three advance together, one tick per enabled clock.
// Pixel coordinates, the pixel strobe, the video-active flag and the line/frame
// end strobes are pure decodes of those registers. They are therefore valid in
// the same cycle as the counters they describe.
module vga_frame_counter #(
    parameter int TICKS_PER_LINE  = 1600,
    parameter int LINES_PER_FRAME = 525,
    parameter int PIX_DIV         = 2,
    parameter int H_VISIBLE       = 640,
    parameter int V_VISIBLE       = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [19:0] cntVertical,
    output logic [10:0] cntHorizontal,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pixel_tick,
    output logic        video_on,
    output logic        line_end,
    output logic        frame_end
);

    localparam int          FRAME_TICKS = TICKS_PER_LINE * LINES_PER_FRAME;
    localparam int          PIX_SHIFT   = $clog2(PIX_DIV);
    localparam logic [10:0] H_LAST      = 11'(TICKS_PER_LINE - 1);
    localparam logic [9:0]  V_LAST      = 10'(LINES_PER_FRAME - 1);
    localparam logic [19:0] F_LAST      = 20'(FRAME_TICKS - 1);
    localparam logic [10:0] PIX_MASK    = 11'(PIX_DIV - 1);
    localparam logic [9:0]  H_VIS       = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS       = 10'(V_VISIBLE);

    logic [10:0] cnt_h_reg, cnt_h_next;
    logic [9:0]  line_reg,  line_next;
    logic [19:0] cnt_v_reg, cnt_v_next;
    logic        h_wrap;
    logic        v_wrap;
    logic [10:0] px_full;

    // The frame counter has its own incrementer.
    // Its wrap is derived from the line/row counters, never from its own value.
    // This keeps the three counters in lockstep by construction.
    always_comb begin
        h_wrap     = (cnt_h_reg == H_LAST);
        v_wrap     = h_wrap && (line_reg == V_LAST);
        cnt_h_next = h_wrap ? 11'd0 : cnt_h_reg + 11'd1;
        line_next  = line_reg;
        if (h_wrap) begin
            line_next = v_wrap ? 10'd0 : line_reg + 10'd1;
        end
        cnt_v_next = v_wrap ? 20'd0 : cnt_v_reg + 20'd1;
    end

    // Counter registers.
    // Reset wins over enable. Enable low freezes all state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_h_reg <= 11'd0;
            line_reg  <= 10'd0;
            cnt_v_reg <= 20'd0;
        end else if (enable) begin
            cnt_h_reg <= cnt_h_next;
            line_reg  <= line_next;
            cnt_v_reg <= cnt_v_next;
        end
    end

    // Output decodes of the registered counters.
    // PIX_DIV is a power of two, so the pixel index is a shift.
    // The end-of-pixel strobe fires when all of the low bits are ones.
    always_comb begin
        px_full       = cnt_h_reg >> PIX_SHIFT;
        cntVertical   = cnt_v_reg;
        cntHorizontal = cnt_h_reg;
        pixel_x       = px_full[9:0];
        pixel_y       = line_reg;
        pixel_tick    = ((cnt_h_reg & PIX_MASK) == PIX_MASK) && (cnt_h_reg != 11'd0 || PIX_DIV == 1);
        video_on      = (px_full[9:0] < H_VIS) && (line_reg < V_VIS);
        line_end      = h_wrap;
        frame_end     = (cnt_v_reg == F_LAST);
    end

endmodule
